// File: rtl/csr_access_ctrl.sv
// CSR access sequencer: decodes Zicsr instructions and drives a read/modify/write
// sequence on the CSR unit. Define CSR_RO_CHECK_EN to make writes to read-only CSRs illegal.
module csr_access_ctrl #(
    parameter int XLEN     = 32,
    parameter int CSR_ADDR = 12,
    parameter int RF_ADDR  = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                instr_valid_i,
    output logic                instr_ready_o,
    input  logic [31:0]         instr_i,
    input  logic [XLEN-1:0]     rs1_val_i,
    output logic [CSR_ADDR-1:0] csr_addr_o,
    output logic                csr_re_o,
    input  logic [XLEN-1:0]     csr_rdata_i,
    output logic                csr_we_o,
    output logic [XLEN-1:0]     csr_wdata_o,
    output logic                rd_we_o,
    output logic [RF_ADDR-1:0]  rd_addr_o,
    output logic [XLEN-1:0]     rd_data_o,
    output logic                illegal_o
);

    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {S_IDLE, S_READ, S_CAPT, S_WRITE, S_RESP} state_t;
    typedef enum logic [1:0] {OP_RW, OP_RS, OP_RC} op_t;

    state_t         state;
    op_t            op_q;
    logic [XLEN-1:0] src_q;
    logic           do_read_q;
    logic           do_write_q;

    logic [6:0]     f_opcode;
    logic [4:0]     f_rd;
    logic [2:0]     f_funct3;
    logic [4:0]     f_rs1;
    logic [11:0]    f_csr;

    assign f_opcode = instr_i[6:0];
    assign f_rd     = instr_i[11:7];
    assign f_funct3 = instr_i[14:12];
    assign f_rs1    = instr_i[19:15];
    assign f_csr    = instr_i[31:20];

    op_t             dec_op;
    logic [XLEN-1:0] dec_src;
    logic            dec_do_read;
    logic            dec_do_write;
    logic            dec_illegal;
    logic            dec_is_csr;
    logic            ro_violation;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        dec_op = OP_RW;
        case (f_funct3[1:0])
            2'b10:   dec_op = OP_RS;
            2'b11:   dec_op = OP_RC;
            default: dec_op = OP_RW;
        endcase
        dec_src      = f_funct3[2] ? XLEN'(f_rs1) : rs1_val_i;
        dec_do_read  = !(dec_op == OP_RW && f_rd == 5'd0);
        // Set/clear forms skip the write based on the rs1 field, not the operand value.
        dec_do_write = (dec_op == OP_RW) || (f_rs1 != 5'd0);
`ifdef CSR_RO_CHECK_EN
        ro_violation = dec_do_write && (f_csr[11:10] == 2'b11);
`else
        ro_violation = 1'b0;
`endif
        dec_illegal  = (f_funct3 == 3'b100) || ro_violation;
        dec_is_csr   = (f_opcode == OPC_SYSTEM) && (f_funct3 != 3'b000);
    end

    function automatic logic [XLEN-1:0] modify(input op_t op, input logic [XLEN-1:0] old,
                                               input logic [XLEN-1:0] src);
        case (op)
            OP_RS:   return old | src;
            OP_RC:   return old & ~src;
            default: return src;
        endcase
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: every register is reset here, including the data holders, so outputs read 0 after reset.
            state         <= S_IDLE;
            instr_ready_o <= 1'b1;
            csr_re_o      <= 1'b0;
            csr_we_o      <= 1'b0;
            rd_we_o       <= 1'b0;
            illegal_o     <= 1'b0;
            csr_addr_o    <= '0;
            csr_wdata_o   <= '0;
            rd_addr_o     <= '0;
            rd_data_o     <= '0;
            op_q          <= OP_RW;
            src_q         <= '0;
            do_read_q     <= 1'b0;
            do_write_q    <= 1'b0;
        end else begin
            csr_re_o  <= 1'b0;
            csr_we_o  <= 1'b0;
            rd_we_o   <= 1'b0;
            illegal_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (instr_valid_i && dec_is_csr) begin
                        instr_ready_o <= 1'b0;
                        csr_addr_o    <= CSR_ADDR'(f_csr);
                        rd_addr_o     <= RF_ADDR'(f_rd);
                        rd_data_o     <= '0;
                        op_q          <= dec_op;
                        src_q         <= dec_src;
                        do_read_q     <= dec_do_read;
                        do_write_q    <= dec_do_write;
                        if (dec_illegal) begin
                            state     <= S_RESP;
                            illegal_o <= 1'b1;
                        end else if (dec_do_read) begin
                            state    <= S_READ;
                            csr_re_o <= 1'b1;
                        end else begin
                            state       <= S_WRITE;
                            csr_we_o    <= 1'b1;
                            csr_wdata_o <= dec_src;
                        end
                    end
                end
                S_READ: state <= S_CAPT;
                S_CAPT: begin
                    rd_data_o <= csr_rdata_i;
                    if (do_write_q) begin
                        state       <= S_WRITE;
                        csr_we_o    <= 1'b1;
                        csr_wdata_o <= modify(op_q, csr_rdata_i, src_q);
                    end else begin
                        state   <= S_RESP;
                        rd_we_o <= rd_addr_o != '0;
                    end
                end
                S_WRITE: begin
                    state   <= S_RESP;
                    rd_we_o <= do_read_q && (rd_addr_o != '0);
                end
                S_RESP: begin
                    state         <= S_IDLE;
                    instr_ready_o <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Directed bench for csr_access_ctrl; per-cycle output traces are compared against
// hand-derived latency masks. Honors CSR_RO_CHECK_EN for the read-only CSR case.
module tb_csr_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid_i;
    logic        instr_ready_o;
    logic [31:0] instr_i;
    logic [31:0] rs1_val_i;
    logic [11:0] csr_addr_o;
    logic        csr_re_o;
    logic [31:0] csr_rdata_i;
    logic        csr_we_o;
    logic [31:0] csr_wdata_o;
    logic        rd_we_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_data_o;
    logic        illegal_o;

    int pass_cnt = 0;
    int total_cnt = 0;

    csr_access_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr_valid_i(instr_valid_i),
        .instr_ready_o(instr_ready_o),
        .instr_i      (instr_i),
        .rs1_val_i    (rs1_val_i),
        .csr_addr_o   (csr_addr_o),
        .csr_re_o     (csr_re_o),
        .csr_rdata_i  (csr_rdata_i),
        .csr_we_o     (csr_we_o),
        .csr_wdata_o  (csr_wdata_o),
        .rd_we_o      (rd_we_o),
        .rd_addr_o    (rd_addr_o),
        .rd_data_o    (rd_data_o),
        .illegal_o    (illegal_o)
    );

    always #5 clk = ~clk;

    // CSR unit model: data valid only in the cycle after a read strobe.
    logic [31:0] csr_val = 32'h0;
    always @(posedge clk) csr_rdata_i <= csr_re_o ? csr_val : 32'hDEAD_0000;

    // Per-cycle traces, bit k = cycle k after the accept edge.
    logic [7:0]  re_v, we_v, rdwe_v, ill_v, rdy_v;
    logic [31:0] wdata_s, rddata_s;
    logic [4:0]  rdaddr_s;
    logic [11:0] addr_s;

    function automatic logic [31:0] enc(input logic [11:0] csr, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
        return {csr, rs1, f3, rd, 7'b1110011};
    endfunction

    task automatic sample(input int k);
        re_v[k]   = csr_re_o;
        we_v[k]   = csr_we_o;
        rdwe_v[k] = rd_we_o;
        ill_v[k]  = illegal_o;
        rdy_v[k]  = instr_ready_o;
        if (csr_we_o) wdata_s = csr_wdata_o;
        if (rd_we_o) begin
            rddata_s = rd_data_o;
            rdaddr_s = rd_addr_o;
        end
        if (csr_re_o || csr_we_o) addr_s = csr_addr_o;
    endtask

    task automatic issue(input logic [31:0] ins, input logic [31:0] rs1v,
                         input logic [31:0] csrv, input bit hold);
        re_v = '0; we_v = '0; rdwe_v = '0; ill_v = '0; rdy_v = '0;
        wdata_s = '0; rddata_s = '0; rdaddr_s = '0; addr_s = '0;
        csr_val = csrv;
        @(negedge clk);
        instr_valid_i = 1'b1;
        instr_i       = ins;
        rs1_val_i     = rs1v;
        #1 sample(0);
        for (int k = 1; k < 8; k++) begin
            @(posedge clk);
            #1 if (!hold) instr_valid_i = 1'b0;
            @(negedge clk);
            sample(k);
        end
        instr_valid_i = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        instr_valid_i = 1'b0;
        instr_i = '0;
        rs1_val_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total_cnt++; if (instr_ready_o !== 1'b1) $display("FAIL reset_ready got=%b exp=1", instr_ready_o); else pass_cnt++;
        total_cnt++; if ({csr_re_o, csr_we_o, rd_we_o, illegal_o} !== 4'b0) $display("FAIL reset_strobes got=%b exp=0000", {csr_re_o, csr_we_o, rd_we_o, illegal_o}); else pass_cnt++;
        total_cnt++; if ({csr_addr_o, rd_addr_o, rd_data_o, csr_wdata_o} !== '0) $display("FAIL reset_data got=%h/%h/%h/%h exp=0", csr_addr_o, rd_addr_o, rd_data_o, csr_wdata_o); else pass_cnt++;
    endtask

    task automatic test_read_only;
        issue(enc(12'hC00, 5'd0, 3'b010, 5'd5), 32'hFFFF_FFFF, 32'h0000_1234, 1'b0);
        total_cnt++; if (re_v !== 8'b0000_0010) $display("FAIL ro_re got=%b exp=00000010", re_v); else pass_cnt++;
        total_cnt++; if (we_v !== 8'b0) $display("FAIL ro_we got=%b exp=00000000", we_v); else pass_cnt++;
        total_cnt++; if (rdwe_v !== 8'b0000_1000) $display("FAIL ro_rdwe got=%b exp=00001000", rdwe_v); else pass_cnt++;
        total_cnt++; if (rdy_v !== 8'b1111_0001) $display("FAIL ro_ready got=%b exp=11110001", rdy_v); else pass_cnt++;
        total_cnt++; if (rddata_s !== 32'h0000_1234 || rdaddr_s !== 5'd5) $display("FAIL ro_rd got=%h@%0d exp=00001234@5", rddata_s, rdaddr_s); else pass_cnt++;
        total_cnt++; if (addr_s !== 12'hC00) $display("FAIL ro_addr got=%h exp=c00", addr_s); else pass_cnt++;
    endtask

    task automatic test_write_only;
        issue(enc(12'h340, 5'd7, 3'b001, 5'd0), 32'hDEAD_BEEF, 32'h1111_1111, 1'b0);
        total_cnt++; if (re_v !== 8'b0) $display("FAIL wo_re got=%b exp=00000000", re_v); else pass_cnt++;
        total_cnt++; if (we_v !== 8'b0000_0010) $display("FAIL wo_we got=%b exp=00000010", we_v); else pass_cnt++;
        total_cnt++; if (wdata_s !== 32'hDEAD_BEEF || addr_s !== 12'h340) $display("FAIL wo_wdata got=%h@%h exp=deadbeef@340", wdata_s, addr_s); else pass_cnt++;
        total_cnt++; if (rdwe_v !== 8'b0) $display("FAIL wo_rdwe got=%b exp=00000000", rdwe_v); else pass_cnt++;
        total_cnt++; if (rdy_v !== 8'b1111_1001) $display("FAIL wo_ready got=%b exp=11111001", rdy_v); else pass_cnt++;
    endtask

    task automatic test_rmw;
        issue(enc(12'h300, 5'd4, 3'b011, 5'd3), 32'h0000_000F, 32'h0000_00FF, 1'b0);
        total_cnt++; if (re_v !== 8'b0000_0010 || we_v !== 8'b0000_1000) $display("FAIL rc_strobes got=re%b we%b exp=re00000010 we00001000", re_v, we_v); else pass_cnt++;
        total_cnt++; if (wdata_s !== 32'h0000_00F0) $display("FAIL rc_wdata got=%h exp=000000f0", wdata_s); else pass_cnt++;
        total_cnt++; if (rdwe_v !== 8'b0001_0000 || rddata_s !== 32'h0000_00FF || rdaddr_s !== 5'd3) $display("FAIL rc_rd got=%b %h@%0d exp=00010000 000000ff@3", rdwe_v, rddata_s, rdaddr_s); else pass_cnt++;
        total_cnt++; if (rdy_v !== 8'b1110_0001) $display("FAIL rc_ready got=%b exp=11100001", rdy_v); else pass_cnt++;

        issue(enc(12'h300, 5'h11, 3'b110, 5'd1), 32'hFFFF_0000, 32'h0000_0100, 1'b0);
        total_cnt++; if (we_v !== 8'b0000_1000 || wdata_s !== 32'h0000_0111) $display("FAIL rsi_wdata got=%b %h exp=00001000 00000111", we_v, wdata_s); else pass_cnt++;
        total_cnt++; if (rdwe_v !== 8'b0001_0000 || rddata_s !== 32'h0000_0100) $display("FAIL rsi_rd got=%b %h exp=00010000 00000100", rdwe_v, rddata_s); else pass_cnt++;

        issue(enc(12'h300, 5'd0, 3'b111, 5'd2), 32'hFFFF_FFFF, 32'h0000_ABCD, 1'b0);
        total_cnt++; if (re_v !== 8'b0000_0010 || we_v !== 8'b0) $display("FAIL rci0_strobes got=re%b we%b exp=re00000010 we00000000", re_v, we_v); else pass_cnt++;
        total_cnt++; if (rdwe_v !== 8'b0000_1000 || rddata_s !== 32'h0000_ABCD) $display("FAIL rci0_rd got=%b %h exp=00001000 0000abcd", rdwe_v, rddata_s); else pass_cnt++;

        // Nonzero rs1 field with a zero operand must still write.
        issue(enc(12'h300, 5'd3, 3'b010, 5'd6), 32'h0, 32'h0000_5A5A, 1'b0);
        total_cnt++; if (we_v !== 8'b0000_1000 || wdata_s !== 32'h0000_5A5A) $display("FAIL rs_field got=%b %h exp=00001000 00005a5a", we_v, wdata_s); else pass_cnt++;
    endtask

    task automatic test_illegal;
        issue(enc(12'h300, 5'd1, 3'b100, 5'd4), 32'h1, 32'h2, 1'b0);
        total_cnt++; if (ill_v !== 8'b0000_0010) $display("FAIL ill_pulse got=%b exp=00000010", ill_v); else pass_cnt++;
        total_cnt++; if ((re_v | we_v | rdwe_v) !== 8'b0) $display("FAIL ill_strobes got=%b exp=00000000", re_v | we_v | rdwe_v); else pass_cnt++;
        total_cnt++; if (rdy_v !== 8'b1111_1101) $display("FAIL ill_ready got=%b exp=11111101", rdy_v); else pass_cnt++;

        issue(enc(12'hC80, 5'd2, 3'b001, 5'd1), 32'h0000_0055, 32'h0000_0077, 1'b0);
`ifdef CSR_RO_CHECK_EN
        total_cnt++; if (ill_v !== 8'b0000_0010) $display("FAIL rocsr_pulse got=%b exp=00000010", ill_v); else pass_cnt++;
        total_cnt++; if ((re_v | we_v | rdwe_v) !== 8'b0) $display("FAIL rocsr_strobes got=%b exp=00000000", re_v | we_v | rdwe_v); else pass_cnt++;
`else
        total_cnt++; if (we_v !== 8'b0000_1000 || wdata_s !== 32'h0000_0055) $display("FAIL rocsr_we got=%b %h exp=00001000 00000055", we_v, wdata_s); else pass_cnt++;
        total_cnt++; if (ill_v !== 8'b0 || rdwe_v !== 8'b0001_0000 || rddata_s !== 32'h0000_0077) $display("FAIL rocsr_rd got=ill%b %b %h exp=ill00000000 00010000 00000077", ill_v, rdwe_v, rddata_s); else pass_cnt++;
`endif
    endtask

    task automatic test_nop;
        issue({12'h300, 5'd2, 3'b001, 5'd1, 7'b0110011}, 32'h5, 32'h6, 1'b0);
        total_cnt++; if (rdy_v !== 8'hFF || (re_v | we_v | rdwe_v | ill_v) !== 8'b0) $display("FAIL nop_opcode got=rdy%b act%b exp=rdy11111111 act00000000", rdy_v, re_v | we_v | rdwe_v | ill_v); else pass_cnt++;
        issue(32'h0000_0073, 32'h5, 32'h6, 1'b0);
        total_cnt++; if (rdy_v !== 8'hFF || (re_v | we_v | rdwe_v | ill_v) !== 8'b0) $display("FAIL nop_funct3 got=rdy%b act%b exp=rdy11111111 act00000000", rdy_v, re_v | we_v | rdwe_v | ill_v); else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        // Valid held high: write-only accepts at cycles 0, 3 and 6.
        issue(enc(12'h340, 5'd7, 3'b001, 5'd0), 32'h1234_5678, 32'h0, 1'b1);
        total_cnt++; if (we_v !== 8'b1001_0010) $display("FAIL b2b_we got=%b exp=10010010", we_v); else pass_cnt++;
        total_cnt++; if (rdy_v !== 8'b0100_1001) $display("FAIL b2b_ready got=%b exp=01001001", rdy_v); else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        logic [7:0] we_after;
        csr_val = 32'h0000_00FF;
        @(negedge clk);
        instr_valid_i = 1'b1;
        instr_i       = enc(12'h300, 5'd4, 3'b011, 5'd3);
        rs1_val_i     = 32'h0000_000F;
        @(posedge clk);
        #1 instr_valid_i = 1'b0;
        @(negedge clk);
        total_cnt++; if (csr_re_o !== 1'b1) $display("FAIL rstmid_re got=%b exp=1", csr_re_o); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        total_cnt++; if ({csr_re_o, csr_we_o, rd_we_o, illegal_o, instr_ready_o} !== 5'b00001) $display("FAIL rstmid_outs got=%b exp=00001", {csr_re_o, csr_we_o, rd_we_o, illegal_o, instr_ready_o}); else pass_cnt++;
        total_cnt++; if ({csr_addr_o, rd_addr_o, rd_data_o, csr_wdata_o} !== '0) $display("FAIL rstmid_data got=%h/%h/%h/%h exp=0", csr_addr_o, rd_addr_o, rd_data_o, csr_wdata_o); else pass_cnt++;
        we_after = '0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            we_after[k] = csr_we_o | rd_we_o;
        end
        total_cnt++; if (we_after !== 8'b0) $display("FAIL rstmid_nowrite got=%b exp=00000000", we_after); else pass_cnt++;
        issue(enc(12'hC00, 5'd0, 3'b010, 5'd5), 32'h0, 32'h0000_4321, 1'b0);
        total_cnt++; if (rdwe_v !== 8'b0000_1000 || rddata_s !== 32'h0000_4321 || rdaddr_s !== 5'd5) $display("FAIL rstmid_next got=%b %h@%0d exp=00001000 00004321@5", rdwe_v, rddata_s, rdaddr_s); else pass_cnt++;
    endtask

    initial begin
        test_reset;
        test_read_only;
        test_write_only;
        test_rmw;
        test_illegal;
        test_nop;
        test_back_to_back;
        test_reset_mid;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
